// File: rtl/reg_writeback_if.sv
// reg_writeback_if
// Groups the writeback block's traffic into one bundle:
//   - ALU result input (alu_valid/alu_rd/alu_data)
//   - load issue notification (ld_issue/ld_issue_rd)
//   - load response handshake (ld_valid/ld_ready/ld_rd/ld_data)
//   - register file write port (reg_write/write_reg/write_data)
//   - status (busy scoreboard, fifo_count, sb_err)
// Modports:
//   - master: the surrounding pipeline, which drives results and consumes status.
//   - slave: the writeback block itself.
interface reg_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  ld_issue;
  logic [ADDR_WIDTH-1:0] ld_issue_rd;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_rd;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [NUM_REGS-1:0]   busy;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic                  sb_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  reg_write, write_reg, write_data,
    input  busy, fifo_count, sb_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output reg_write, write_reg, write_data,
    output busy, fifo_count, sb_err
  );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback
// Drives the register file write port from two sources: single-cycle ALU
// results, which always win, and load responses, which are buffered in a
// small circular FIFO and drained whenever the ALU is not writing. A per-
// register scoreboard tracks outstanding loads for hazard logic, and a
// sticky error flag records scoreboard protocol violations.
// Ports:
//   - clk: clock, all state updates on posedge.
//   - rst: synchronous active-high reset.
//   - bus: reg_writeback_if.slave carrying the ALU/load inputs, the
//     registered register file write port and the status outputs.
module reg_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  reg_writeback_if.slave  bus
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fifo_rd_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  sb_err_q, sb_err_d;

  logic                  ld_ready;
  logic                  accept;
  logic                  alu_wr;
  logic                  pop;
  logic                  pop_wr;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   clr_mask;

  // Handshake and arbitration. An ALU write to x0 is a no-op, so it does not
  // steal the write port from the FIFO; a popped entry for x0 is discarded.
  assign ld_ready  = !rst && (count_q != CNT_WIDTH'(FIFO_DEPTH));
  assign accept    = bus.ld_valid && ld_ready;
  assign alu_wr    = bus.alu_valid && (bus.alu_rd != '0);
  assign pop       = !alu_wr && (count_q != '0);
  assign head_rd   = fifo_rd_mem[rd_ptr_q];
  assign head_data = fifo_data_mem[rd_ptr_q];
  assign pop_wr    = pop && (head_rd != '0);

  // Next register file write. Index and data hold when nothing is written.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_wr) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.alu_rd;
      write_data_d = bus.alu_data;
    end else if (pop_wr) begin
      reg_write_d  = 1'b1;
      write_reg_d  = head_rd;
      write_data_d = head_data;
    end
  end

  // FIFO bookkeeping. Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(accept);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop);
    count_d  = count_q + CNT_WIDTH'(accept) - CNT_WIDTH'(pop);
  end

  // Scoreboard update and protocol checks. A set on the same edge as a clear
  // of the same register wins, since the newer load is still outstanding.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.ld_issue && (bus.ld_issue_rd != '0)) begin
      set_mask[bus.ld_issue_rd] = 1'b1;
    end
    if (pop_wr) begin
      clr_mask[head_rd] = 1'b1;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;

    sb_err_d = sb_err_q;
    if ((set_mask != '0) && busy_q[bus.ld_issue_rd] && !clr_mask[bus.ld_issue_rd]) begin
      sb_err_d = 1'b1;
    end
    if (alu_wr && busy_q[bus.alu_rd]) begin
      sb_err_d = 1'b1;
    end
    if (pop_wr && !busy_q[head_rd]) begin
      sb_err_d = 1'b1;
    end
  end

  // Entry storage needs no reset: nothing is read until count shows it valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_rd_mem[wr_ptr_q]   <= bus.ld_rd;
      fifo_data_mem[wr_ptr_q] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
      sb_err_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      sb_err_q     <= sb_err_d;
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count_q;
  assign bus.sb_err     = sb_err_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback
// Directed bench for reg_writeback: reset, ALU writes, single load, FIFO
// fill under ALU pressure, full-FIFO backpressure, pointer wrap with
// simultaneous accept/pop, x0 handling, scoreboard error and mid-run reset.
module tb_reg_writeback;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  reg_writeback_if bus ();

  reg_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set afterwards apply to the next edge and
  // outputs read afterwards reflect the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.ld_issue    = 1'b0;
    bus.ld_issue_rd = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_data     = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ld_ready_low: got %0d want 0", bus.ld_ready); end
    rst = 1'b0;
    tick();
    total++; if (bus.reg_write !== 1'b0) begin bad++; $display("[TB] FAIL rst_reg_write: got %0d want 0", bus.reg_write); end
    total++; if (bus.write_reg !== 5'd0) begin bad++; $display("[TB] FAIL rst_write_reg: got %0d want 0", bus.write_reg); end
    total++; if (bus.write_data !== 32'h0) begin bad++; $display("[TB] FAIL rst_write_data: got %0h want 0", bus.write_data); end
    total++; if (bus.busy !== 32'h0) begin bad++; $display("[TB] FAIL rst_busy: got %0h want 0", bus.busy); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL rst_fifo_count: got %0d want 0", bus.fifo_count); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_sb_err: got %0d want 0", bus.sb_err); end
    total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ld_ready_high: got %0d want 1", bus.ld_ready); end
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    total++; if (bus.reg_write !== 1'b1) begin bad++; $display("[TB] FAIL alu_we: got %0d want 1", bus.reg_write); end
    total++; if (bus.write_reg !== 5'd5) begin bad++; $display("[TB] FAIL alu_reg: got %0d want 5", bus.write_reg); end
    total++; if (bus.write_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL alu_data: got %0h want deadbeef", bus.write_data); end
    bus.alu_valid = 1'b0;
    tick();
    total++; if (bus.reg_write !== 1'b0) begin bad++; $display("[TB] FAIL alu_we_drop: got %0d want 0", bus.reg_write); end
    total++; if (bus.write_reg !== 5'd5) begin bad++; $display("[TB] FAIL alu_reg_hold: got %0d want 5", bus.write_reg); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    tick();
    total++; if (bus.reg_write !== 1'b0) begin bad++; $display("[TB] FAIL alu_x0_we: got %0d want 0", bus.reg_write); end
    total++; if (bus.write_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL alu_x0_data_hold: got %0h want deadbeef", bus.write_data); end
    idle_inputs();
  endtask

  task automatic test_load_single();
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
    tick();
    bus.ld_issue = 1'b0;
    total++; if (bus.busy !== 32'h80) begin bad++; $display("[TB] FAIL ld_busy_set: got %0h want 80", bus.busy); end
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h1234;
    tick();
    bus.ld_valid = 1'b0;
    total++; if (bus.reg_write !== 1'b0) begin bad++; $display("[TB] FAIL ld_no_bypass: got %0d want 0", bus.reg_write); end
    total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("[TB] FAIL ld_count1: got %0d want 1", bus.fifo_count); end
    total++; if (bus.busy !== 32'h80) begin bad++; $display("[TB] FAIL ld_busy_held: got %0h want 80", bus.busy); end
    tick();
    total++; if (bus.reg_write !== 1'b1) begin bad++; $display("[TB] FAIL ld_we: got %0d want 1", bus.reg_write); end
    total++; if (bus.write_reg !== 5'd7) begin bad++; $display("[TB] FAIL ld_reg: got %0d want 7", bus.write_reg); end
    total++; if (bus.write_data !== 32'h1234) begin bad++; $display("[TB] FAIL ld_data: got %0h want 1234", bus.write_data); end
    total++; if (bus.busy !== 32'h0) begin bad++; $display("[TB] FAIL ld_busy_clr: got %0h want 0", bus.busy); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL ld_count0: got %0d want 0", bus.fifo_count); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("[TB] FAIL ld_sb_err: got %0d want 0", bus.sb_err); end
  endtask

  task automatic test_fill_under_alu();
    for (int i = 1; i <= 4; i++) begin
      bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'(i);
      tick();
    end
    bus.ld_issue = 1'b0;
    total++; if (bus.busy !== 32'h1E) begin bad++; $display("[TB] FAIL fill_busy: got %0h want 1e", bus.busy); end
    for (int c = 0; c < 6; c++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(10 + c); bus.alu_data = 32'hA000 + 32'(c);
      bus.ld_valid  = 1'b1;
      bus.ld_rd     = (c < 4) ? 5'(c + 1) : 5'd5;
      bus.ld_data   = (c < 4) ? 32'h100 + 32'(c) : 32'hBAD;
      tick();
      total++; if (bus.write_reg !== 5'(10 + c) || bus.reg_write !== 1'b1) begin bad++; $display("[TB] FAIL fill_alu_wins c=%0d: got we=%0d reg=%0d want we=1 reg=%0d", c, bus.reg_write, bus.write_reg, 10 + c); end
      total++; if (bus.fifo_count !== ((c < 4) ? 3'(c + 1) : 3'd4)) begin bad++; $display("[TB] FAIL fill_count c=%0d: got %0d", c, bus.fifo_count); end
    end
    total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_ld_ready_full: got %0d want 0", bus.ld_ready); end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'(i + 1) || bus.write_data !== 32'h100 + 32'(i)) begin bad++; $display("[TB] FAIL drain_order i=%0d: got we=%0d reg=%0d data=%0h want we=1 reg=%0d data=%0h", i, bus.reg_write, bus.write_reg, bus.write_data, i + 1, 32'h100 + i); end
      total++; if (bus.fifo_count !== 3'(3 - i)) begin bad++; $display("[TB] FAIL drain_count i=%0d: got %0d want %0d", i, bus.fifo_count, 3 - i); end
    end
    tick();
    total++; if (bus.reg_write !== 1'b0) begin bad++; $display("[TB] FAIL drain_idle_we: got %0d want 0", bus.reg_write); end
    total++; if (bus.busy !== 32'h0) begin bad++; $display("[TB] FAIL drain_busy: got %0h want 0", bus.busy); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("[TB] FAIL drain_sb_err: got %0d want 0", bus.sb_err); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'(16 + i);
      tick();
    end
    bus.ld_issue = 1'b0;
    total++; if (bus.busy !== 32'h03FF0000) begin bad++; $display("[TB] FAIL b2b_busy: got %0h want 3ff0000", bus.busy); end
    for (int k = 0; k < 10; k++) begin
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(16 + k); bus.ld_data = 32'hC0DE0000 + 32'(k);
      tick();
      if (k > 0) begin
        total++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'(15 + k) || bus.write_data !== 32'hC0DE0000 + 32'(k - 1)) begin bad++; $display("[TB] FAIL b2b_order k=%0d: got we=%0d reg=%0d data=%0h", k, bus.reg_write, bus.write_reg, bus.write_data); end
      end
      total++; if (bus.fifo_count !== 3'd1) begin bad++; $display("[TB] FAIL b2b_count k=%0d: got %0d want 1", k, bus.fifo_count); end
    end
    bus.ld_valid = 1'b0;
    tick();
    total++; if (bus.write_reg !== 5'd25 || bus.write_data !== 32'hC0DE0009) begin bad++; $display("[TB] FAIL b2b_last: got reg=%0d data=%0h want reg=25 data=c0de0009", bus.write_reg, bus.write_data); end
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL b2b_empty: got %0d want 0", bus.fifo_count); end
    total++; if (bus.busy !== 32'h0 || bus.sb_err !== 1'b0) begin bad++; $display("[TB] FAIL b2b_sb: got busy=%0h err=%0d want 0 0", bus.busy, bus.sb_err); end
  endtask

  task automatic test_x0_handling();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hFFFF;
    tick();
    bus.ld_valid = 1'b0;
    tick();
    total++; if (bus.reg_write !== 1'b0 || bus.write_reg !== 5'd25) begin bad++; $display("[TB] FAIL x0_discard: got we=%0d reg=%0d want we=0 reg=25", bus.reg_write, bus.write_reg); end
    total++; if (bus.fifo_count !== 3'd0 || bus.sb_err !== 1'b0) begin bad++; $display("[TB] FAIL x0_discard_pop: got count=%0d err=%0d want 0 0", bus.fifo_count, bus.sb_err); end
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd3;
    tick();
    bus.ld_issue = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'hA5;
    tick();
    bus.ld_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h77;
    tick();
    total++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd3 || bus.write_data !== 32'hA5) begin bad++; $display("[TB] FAIL x0_alu_no_block: got we=%0d reg=%0d data=%0h want 1 3 a5", bus.reg_write, bus.write_reg, bus.write_data); end
    idle_inputs();
  endtask

  task automatic test_sb_err();
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9;
    tick();
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("[TB] FAIL sb_first_issue: got %0d want 0", bus.sb_err); end
    tick();
    bus.ld_issue = 1'b0;
    total++; if (bus.sb_err !== 1'b1) begin bad++; $display("[TB] FAIL sb_double_issue: got %0d want 1", bus.sb_err); end
    tick();
    total++; if (bus.sb_err !== 1'b1) begin bad++; $display("[TB] FAIL sb_sticky: got %0d want 1", bus.sb_err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'(11 + i);
      tick();
    end
    bus.ld_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'(i);
      bus.ld_valid  = 1'b1; bus.ld_rd = 5'(11 + i); bus.ld_data = 32'hE0 + 32'(i);
      tick();
    end
    idle_inputs();
    total++; if (bus.fifo_count !== 3'd3) begin bad++; $display("[TB] FAIL mid_buffered: got %0d want 3", bus.fifo_count); end
    rst = 1'b1;
    tick();
    total++; if (bus.fifo_count !== 3'd0 || bus.busy !== 32'h0 || bus.sb_err !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_state: got count=%0d busy=%0h err=%0d want 0 0 0", bus.fifo_count, bus.busy, bus.sb_err); end
    total++; if (bus.reg_write !== 1'b0 || bus.write_data !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_port: got we=%0d data=%0h want 0 0", bus.reg_write, bus.write_data); end
    total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_ready: got %0d want 0", bus.ld_ready); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.reg_write !== 1'b0 || bus.fifo_count !== 3'd0) begin bad++; $display("[TB] FAIL mid_no_writes i=%0d: got we=%0d count=%0d want 0 0", i, bus.reg_write, bus.fifo_count); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_load_single();
    test_fill_under_alu();
    test_back_to_back();
    test_x0_handling();
    test_sb_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writeback-side driver for the 32x32 register file write port (reg_write / write_reg / write_data).
- Merges two result sources:
  - single-cycle ALU results, which cannot stall;
  - multi-cycle load responses, buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard for hazard logic.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_WIDTH, 32, width of result data and write_data.
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers.
- FIFO_DEPTH, 4, load-response buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending.
- ld_issue_rd  in  ADDR_WIDTH  destination of the issued load.
- ld_valid  in  1  load response offered.
- ld_ready  out  1  FIFO can accept a load response.
- ld_rd  in  ADDR_WIDTH  load response destination.
- ld_data  in  DATA_WIDTH  load response data.
- reg_write  out  1  register file write enable, registered.
- write_reg  out  ADDR_WIDTH  register file write index, registered.
- write_data  out  DATA_WIDTH  register file write data, registered.
- busy  out  2**ADDR_WIDTH  scoreboard bitmap; bit i set means a load to xi is outstanding.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- sb_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at posedge): reg_write=0, write_reg=0, write_data=0, busy=0, FIFO emptied (fifo_count=0), sb_err=0, ld_ready=0 while rst is high.
  - Reset mid-operation discards all buffered loads and pending bits.
- ld_ready = !rst && (fifo_count != FIFO_DEPTH), combinational.
  - Accept happens when ld_valid && ld_ready; the entry is enqueued at that posedge.
- Per-cycle selection, registered at posedge into reg_write/write_reg/write_data:
  - alu_valid && alu_rd!=0: write the ALU result. Latency 1 cycle. FIFO does not drain this cycle.
  - Otherwise, if FIFO is non-empty: pop the head.
    - head rd!=0: write it.
    - head rd==0: pop with reg_write=0 (discarded).
  - Otherwise: reg_write=0. write_reg/write_data hold their last values.
- ALU with rd==0 produces no write and does not block a FIFO drain.
- Load path latency: accepted at edge N, earliest write visible after edge N+1; there is no bypass of the empty FIFO.
- Simultaneous accept and pop in the same cycle is allowed; fifo_count stays unchanged.
- The FIFO is circular; read/write pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - ld_issue && ld_issue_rd!=0 sets busy[ld_issue_rd] at the posedge.
  - A popped load entry with rd!=0 clears busy[rd] on the same edge that raises reg_write for it.
  - Set and clear of the same bit on one edge: set wins.
  - busy[0] is always 0.
- sb_err is set (sticky until rst) on any of:
  - ld_issue to an already-busy rd (without a same-edge clear);
  - alu_valid with alu_rd!=0 targeting a busy rd (write still performed);
  - a load entry popped whose rd bit is not busy (write still performed).
- Pure RTL. No combinational path from ld_valid to the register file outputs.

Test Plan:
- rst held 2 cycles, then released, idle -> all outputs 0, ld_ready=1, fifo_count=0, busy=0.
- alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at edge N -> reg_write=1, write_reg=5, write_data=0xDEADBEEF after edge N, then reg_write=0; alu_rd=0 -> no write.
- ld_issue rd=7, then ld_valid rd=7 data=0x1234 at edge N, no ALU traffic -> busy[7]=1 until write; write_reg=7, write_data=0x1234 after edge N+1; busy[7]=0 at the same time; sb_err=0.
- Enqueue 4 loads (rd 1..4, each issued first) while alu_valid stays high for 6 cycles:
  - ld_ready=0 once fifo_count=4;
  - no load writes during the ALU cycles;
  - after ALU stops, loads write x1..x4 in order on consecutive cycles;
  - fifo_count returns to 0.
- Enqueue at full with ld_valid=1 and ld_ready=0 -> no accept and no overflow; fill/drain 10 entries to confirm pointer wrap and order.
- Fault and reset cases:
  - ld_issue rd=9 twice with no intervening writeback -> sb_err=1 and sticky;
  - assert rst with 3 entries buffered -> fifo_count=0, busy=0, sb_err=0, no further writes.
